comparison_unit_iter: RTL and testbench



---
 rtl/comparison_unit_iter.sv | 172 +++++++++++++++++
 tb/tb_comparison_unit_iter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparison_unit_iter.sv
// Iterative relational comparator: walks the operands MSB-first, CHUNK bits per
// cycle, and stops at the first differing chunk. Result is a zero-extended flag.
module comparison_unit_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(N - 1);
  localparam logic [IDXW-1:0]  IDX_ONE   = IDXW'(1);
  localparam logic [IDXW-1:0]  IDX_ZERO  = {IDXW{1'b0}};
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b010;
  localparam logic [2:0] OP_GE  = 3'b011;
  localparam logic [2:0] OP_LTU = 3'b100;
  localparam logic [2:0] OP_GEU = 3'b101;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("comparison_unit_iter: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic decode_flag(input logic [2:0] op_v,
                                       input logic       eq_v,
                                       input logic       lt_v);
    logic flag_v;
    case (op_v)
      OP_EQ:   flag_v = eq_v;
      OP_NE:   flag_v = ~eq_v;
      OP_LT:   flag_v = lt_v;
      OP_GE:   flag_v = ~lt_v;
      OP_LTU:  flag_v = lt_v;
      OP_GEU:  flag_v = ~lt_v;
      default: flag_v = 1'b0;
    endcase
    return flag_v;
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op_v);
    return (op_v == OP_LT) || (op_v == OP_GE);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [N-1:0][CHUNK-1:0] a_chunks_s;
  logic [N-1:0][CHUNK-1:0] b_chunks_s;
  logic [CHUNK-1:0]        a_cur_s;
  logic [CHUNK-1:0]        b_cur_s;
  logic                    chunk_eq_s;
  logic                    chunk_lt_s;

  assign a_chunks_s = a_q;
  assign b_chunks_s = b_q;
  assign a_cur_s    = a_chunks_s[idx_q];
  assign b_cur_s    = b_chunks_s[idx_q];
  assign chunk_eq_s = (a_cur_s == b_cur_s);
  assign chunk_lt_s = (a_cur_s < b_cur_s);

  // Signed ops flip both MSBs at latch time so the chunk walk stays unsigned.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    idx_d       = idx_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a ^ (is_signed_op(op) ? SIGN_MASK : ZERO_W);
          b_d     = b ^ (is_signed_op(op) ? SIGN_MASK : ZERO_W);
          op_d    = op;
          idx_d   = IDX_TOP;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!chunk_eq_s) begin
          result_d    = {{(WIDTH-1){1'b0}}, decode_flag(op_q, 1'b0, chunk_lt_s)};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (idx_q == IDX_ZERO) begin
          result_d    = {{(WIDTH-1){1'b0}}, decode_flag(op_q, 1'b1, 1'b0)};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= ZERO_W;
      b_q         <= ZERO_W;
      op_q        <= 3'b000;
      idx_q       <= IDX_ZERO;
      result_q    <= ZERO_W;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_comparison_unit_iter.sv
// Self-checking bench for comparison_unit_iter: three configurations (32/8, 32/32,
// 64/16) checked every cycle against a transaction-level reference model.
module tb_comparison_unit_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic [2:0]  op_s;
  logic [63:0] a_s, b_s;
  logic        iv0, iv1, iv2;
  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        bz0, bz1, bz2;
  logic [31:0] r0, r1;
  logic [63:0] r2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  comparison_unit_iter #(.WIDTH(32), .CHUNK(8)) u_c0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a_s[31:0]), .b(b_s[31:0]),
    .op(op_s), .out_valid(ov0), .out_ready(out_ready), .result(r0), .busy(bz0));
  comparison_unit_iter #(.WIDTH(32), .CHUNK(32)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a_s[31:0]), .b(b_s[31:0]),
    .op(op_s), .out_valid(ov1), .out_ready(out_ready), .result(r1), .busy(bz1));
  comparison_unit_iter #(.WIDTH(64), .CHUNK(16)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a_s), .b(b_s),
    .op(op_s), .out_valid(ov2), .out_ready(out_ready), .result(r2), .busy(bz2));

  function automatic int cw(input int g);
    return (g == 2) ? 64 : 32;
  endfunction

  function automatic int cc(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 32 : 16);
  endfunction

  function automatic logic get_iv(input int g);
    return (g == 0) ? iv0 : ((g == 1) ? iv1 : iv2);
  endfunction

  function automatic logic get_ir(input int g);
    return (g == 0) ? ir0 : ((g == 1) ? ir1 : ir2);
  endfunction

  function automatic logic get_ov(input int g);
    return (g == 0) ? ov0 : ((g == 1) ? ov1 : ov2);
  endfunction

  function automatic logic get_bz(input int g);
    return (g == 0) ? bz0 : ((g == 1) ? bz1 : bz2);
  endfunction

  function automatic logic [63:0] get_res(input int g);
    return (g == 0) ? {32'h0, r0} : ((g == 1) ? {32'h0, r1} : r2);
  endfunction

  function automatic logic [63:0] in_a(input int g);
    return (g == 2) ? a_s : {32'h0, a_s[31:0]};
  endfunction

  function automatic logic [63:0] in_b(input int g);
    return (g == 2) ? b_s : {32'h0, b_s[31:0]};
  endfunction

  task automatic set_iv(input int g, input logic v);
    case (g)
      0:       iv0 = v;
      1:       iv1 = v;
      default: iv2 = v;
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: relational outcome from plain signed/unsigned arithmetic, and the
  // number of chunks examined = position of the most significant differing chunk.
  function automatic void ref_compare(input int w, input int c, input logic [63:0] a,
                                      input logic [63:0] b, input logic [2:0] op,
                                      output logic flag, output int k);
    logic [63:0] m, cm, aa, bb;
    logic        eq, ltu, lts, found;
    int          n;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    cm = (c == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << c) - 64'd1);
    aa = a & m;
    bb = b & m;
    n  = w / c;
    k  = n;
    found = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!found && (((aa >> (i * c)) & cm) != ((bb >> (i * c)) & cm))) begin
        k     = n - i;
        found = 1'b1;
      end
    end
    eq  = (aa == bb);
    ltu = (aa < bb);
    lts = (aa[w-1] != bb[w-1]) ? aa[w-1] : ltu;
    case (op)
      3'b000:  flag = eq;
      3'b001:  flag = !eq;
      3'b010:  flag = lts;
      3'b011:  flag = !lts;
      3'b100:  flag = ltu;
      3'b101:  flag = !ltu;
      default: flag = 1'b0;
    endcase
  endfunction

  bit          m_busy [3] = '{1'b0, 1'b0, 1'b0};
  bit          m_ov   [3] = '{1'b0, 1'b0, 1'b0};
  int          m_cnt  [3] = '{0, 0, 0};
  logic        m_flag [3] = '{1'b0, 1'b0, 1'b0};
  logic [63:0] m_res  [3] = '{64'h0, 64'h0, 64'h0};

  // Cycle-level transaction tracker per configuration.
  initial begin : model_proc
    logic mf;
    int   mk;
    forever begin
      @(posedge clk or posedge rst);
      for (int g = 0; g < 3; g++) begin
        if (rst) begin
          m_busy[g] = 1'b0;
          m_ov[g]   = 1'b0;
          m_cnt[g]  = 0;
          m_res[g]  = 64'h0;
        end else if (m_ov[g]) begin
          if (out_ready) begin
            m_ov[g]   = 1'b0;
            m_busy[g] = 1'b0;
          end
        end else if (m_busy[g]) begin
          m_cnt[g]--;
          if (m_cnt[g] == 0) begin
            m_ov[g]  = 1'b1;
            m_res[g] = {63'h0, m_flag[g]};
          end
        end else if (get_iv(g)) begin
          ref_compare(cw(g), cc(g), in_a(g), in_b(g), op_s, mf, mk);
          m_flag[g] = mf;
          m_cnt[g]  = mk;
          m_busy[g] = 1'b1;
        end
      end
    end
  end

  initial begin : compare_proc
    forever begin
      @(posedge clk);
      #2;
      for (int g = 0; g < 3; g++) begin
        check($sformatf("cfg%0d in_ready", g), {63'h0, get_ir(g)}, {63'h0, (!m_busy[g] && !rst)});
        check($sformatf("cfg%0d out_valid", g), {63'h0, get_ov(g)}, {63'h0, m_ov[g]});
        check($sformatf("cfg%0d busy", g), {63'h0, get_bz(g)}, {63'h0, m_busy[g]});
        check($sformatf("cfg%0d result", g), get_res(g), m_res[g]);
      end
    end
  end

  // Starts at a negedge with the unit idle; returns captured result and latency.
  task automatic do_txn(input int g, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input int hold, input bit pulse,
                        output logic [63:0] res, output int lat);
    int t;
    int lim;
    lim = cw(g) / cc(g) + 2;
    t = 0;
    while (!get_ir(g) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("cfg%0d accept_wait", g), {63'h0, get_ir(g)}, 64'h1);
    a_s  = a;
    b_s  = b;
    op_s = op;
    set_iv(g, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_iv(g, 1'b0);
    a_s  = {$urandom, $urandom};
    b_s  = {$urandom, $urandom};
    op_s = 3'($urandom_range(0, 7));
    lat = 0;
    while (!get_ov(g) && lat < lim) begin
      set_iv(g, pulse && ($urandom_range(0, 1) == 1));
      @(negedge clk);
      lat++;
    end
    set_iv(g, 1'b0);
    check($sformatf("cfg%0d out_valid_wait", g), {63'h0, get_ov(g)}, 64'h1);
    res = get_res(g);
    for (int h = 0; h < hold; h++) begin
      set_iv(g, pulse && (h == 0));
      a_s = {$urandom, $urandom};
      b_s = a_s;
      @(negedge clk);
    end
    set_iv(g, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp;
    int          lat0;
    int          lat1;
    int          lat2;
    int          hold;
    bit          pulse;
  } dir_t;

  dir_t dirs [10];

  function automatic int pick_lat(input dir_t d, input int g);
    return (g == 0) ? d.lat0 : ((g == 1) ? d.lat1 : d.lat2);
  endfunction

  function automatic logic [63:0] widen(input int g, input logic [31:0] v);
    return (g == 2) ? {{32{v[31]}}, v} : {32'h0, v};
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [63:0] res, ra, rb;
    int          lat, mk, mode;
    logic        mf;

    dirs[0] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 1, 1, 0, 1'b0};
    dirs[1] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 1, 1, 0, 1'b0};
    dirs[2] = '{3'b100, 32'h0001_0000, 32'h0000_FFFF, 1'b0, 2, 1, 3, 0, 1'b0};
    dirs[3] = '{3'b000, 32'h1234_5678, 32'h1234_5678, 1'b1, 4, 1, 4, 5, 1'b1};
    dirs[4] = '{3'b001, 32'h1234_5678, 32'h1234_5678, 1'b0, 4, 1, 4, 0, 1'b0};
    dirs[5] = '{3'b011, 32'h0000_0105, 32'h0000_0106, 1'b0, 4, 1, 4, 2, 1'b1};
    dirs[6] = '{3'b110, 32'h0000_0005, 32'h0000_0009, 1'b0, 4, 1, 4, 0, 1'b0};
    dirs[7] = '{3'b011, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, 1, 1, 0, 1'b0};
    dirs[8] = '{3'b010, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1, 1, 1, 0, 1'b0};
    dirs[9] = '{3'b101, 32'h0000_0000, 32'h0000_0000, 1'b1, 4, 1, 4, 0, 1'b0};

    rst = 1'b1; out_ready = 1'b0; op_s = 3'b000; a_s = 64'h0; b_s = 64'h0;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("cfg%0d reset in_ready", g), {63'h0, get_ir(g)}, 64'h0);
      check($sformatf("cfg%0d reset out_valid", g), {63'h0, get_ov(g)}, 64'h0);
      check($sformatf("cfg%0d reset busy", g), {63'h0, get_bz(g)}, 64'h0);
      check($sformatf("cfg%0d reset result", g), get_res(g), 64'h0);
    end
    rst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++)
      check($sformatf("cfg%0d in_ready after reset", g), {63'h0, get_ir(g)}, 64'h1);
    @(negedge clk);

    for (int g = 0; g < 3; g++) begin
      for (int d = 0; d < 10; d++) begin
        ra = widen(g, dirs[d].a);
        rb = widen(g, dirs[d].b);
        ref_compare(cw(g), cc(g), ra, rb, dirs[d].op, mf, mk);
        check($sformatf("cfg%0d dir%0d model flag", g, d), {63'h0, mf}, {63'h0, dirs[d].exp});
        check($sformatf("cfg%0d dir%0d model chunks", g, d), 64'(mk), 64'(pick_lat(dirs[d], g)));
        do_txn(g, dirs[d].op, ra, rb, dirs[d].hold, dirs[d].pulse, res, lat);
        check($sformatf("cfg%0d dir%0d result", g, d), res, {63'h0, dirs[d].exp});
        check($sformatf("cfg%0d dir%0d latency", g, d), 64'(lat), 64'(pick_lat(dirs[d], g)));
      end

      // Reset two compare cycles into an EQ of equal operands.
      a_s = 64'h1234_5678; b_s = 64'h1234_5678; op_s = 3'b000;
      set_iv(g, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_iv(g, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check($sformatf("cfg%0d midrun out_valid", g), {63'h0, get_ov(g)}, 64'h0);
      check($sformatf("cfg%0d midrun result", g), get_res(g), 64'h0);
      check($sformatf("cfg%0d midrun busy", g), {63'h0, get_bz(g)}, 64'h0);
      check($sformatf("cfg%0d midrun in_ready", g), {63'h0, get_ir(g)}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check($sformatf("cfg%0d post-reset in_ready", g), {63'h0, get_ir(g)}, 64'h1);
      @(negedge clk);
      do_txn(g, 3'b000, 64'h1234_5678, 64'h1234_5678, 0, 1'b0, res, lat);
      check($sformatf("cfg%0d post-reset result", g), res, 64'h1);
      check($sformatf("cfg%0d post-reset latency", g), 64'(lat), 64'(pick_lat(dirs[3], g)));

      for (int t = 0; t < 120; t++) begin
        ra   = {$urandom, $urandom};
        mode = $urandom_range(0, 3);
        case (mode)
          0:       rb = {$urandom, $urandom};
          1:       rb = ra;
          2:       rb = ra ^ (64'd1 << $urandom_range(0, 63));
          default: rb = ra ^ (64'd1 << $urandom_range(0, 15));
        endcase
        do_txn(g, 3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3),
               bit'($urandom_range(0, 1)), res, lat);
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
